bcd_timer_ud_n: RTL and testbench
=================================

Name: bcd_timer_ud_n

Overview:
Parametrised multi-digit loadable up/down BCD counter with per-digit modulus. It is the common time-keeping core for the stopwatch, kitchen-timer and clock-set modes. It consumes a one-cycle time-base pulse from the existing usec/msec/sec dividers. It replaces the fixed 60/100 and separate up/down counters with one block supporting wrap or saturate, terminal-count pulses, a done flag and manual adjust.

Parameters:
DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
SEX_MASK, 4'b1010, bit i = 1 makes digit i modulo 6, else modulo 10. The default gives mm:ss with max 59:59. Width is DIGITS.
WRAP, 1, 1 = wrap at limits; 0 = saturate at limits.

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous, active-high reset
tick  in  1  one-clk time-base pulse; counts one step when run=1
run  in  1  1 = counting on tick; 0 = paused, manual adjust allowed
dir  in  1  1 = count up, 0 = count down
load  in  1  synchronous load of load_value
load_value  in  4*DIGITS  BCD value, digit i at [4i+3:4i]
inc  in  1  one-clk pulse, +1 on digit chain (run=0 only)
dec  in  1  one-clk pulse, -1 on digit chain (run=0 only)
digits  out  4*DIGITS  current BCD count, registered
ovf  out  1  one-clk pulse, up step attempted from all-max
udf  out  1  one-clk pulse, down step attempted from all-zero
done  out  1  level, count reached zero by a down step

Behaviour:
- Clock and reset: one clock, clk. Reset reset_p is asynchronous, active-high.
- Reset values: digits=0, ovf=0, udf=0, done=0. Reset mid-count clears immediately, with no pending step.
- All outputs are registered. An event sampled at edge k is visible after edge k.
- Step source per cycle, in priority order:
  - load: digits <= load_value with clamping; done <= 0; no ovf/udf.
  - else if run=0 and exactly one of inc/dec is high: one step, up for inc, down for dec.
  - else if run=1 and tick=1: one step in the direction given by dir.
  - else: hold.
- Ignored inputs:
  - inc and dec both high: ignored.
  - inc/dec while run=1: ignored.
  - tick while run=0: ignored.
- Load clamping: any digit of load_value at or above its modulus loads as modulus-1. Example: 9 into a mod-6 digit loads 5; 0xC into a mod-10 digit loads 9.
- Up step (ripple in one cycle):
  - Digit 0 increments.
  - A digit at modulus-1 becomes 0 and carries into the next digit.
  - Carry out of the top digit: ovf=1 for one cycle.
    - WRAP=1: the result is all-zero.
    - WRAP=0: digits stay at all-max, unchanged.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 becomes modulus-1 and borrows from the next digit.
  - Borrow out of the top digit: udf=1 for one cycle.
    - WRAP=1: the result is all-max.
    - WRAP=0: digits stay all-zero.
- done:
  - Set on the edge where a down step produces an all-zero value from a nonzero value.
  - Stays set on further down steps at zero.
  - Cleared by load, by any up step, or by reset.
  - A load of zero does not set done.
- ovf/udf are low in every cycle without a boundary step. Back-to-back boundary steps give back-to-back pulses.
- No combinational path from inputs to outputs.
- Step arithmetic is 4 bits per digit. Digits never hold values at or above their modulus.

Test Plan (DIGITS=4, SEX_MASK=4'b1010, WRAP=1 unless stated):
- Reset mid-count: load 0x1234, run=1, 5 ticks, assert reset_p between edges -> digits=0x0000 immediately; ovf=udf=done=0.
- Up wrap: load 0x5958, dir=1, 2 ticks -> 0x5959, then 0x0000 with ovf high exactly one cycle. Also check 0x0959 -> 0x1000 (mod-6 carry).
- Countdown done: load 0x0002, dir=0, 2 ticks -> 0x0001, then 0x0000 with done=1. A 3rd tick gives 0x5959 with udf pulse and done=0 on the following up... Expected with WRAP=1: 0x5959, udf=1, done stays 1 until load.
- Saturate (WRAP=0): load 0x0000, dir=0, tick -> digits 0x0000, udf one pulse. Load 0x5959, dir=1, tick -> 0x5959, ovf one pulse.
- Manual adjust/priority: run=0, inc -> +1, dec -> -1. inc+dec together -> hold. tick with run=0 -> hold. load with inc in the same cycle -> load wins. inc with run=1 -> ignored.
- Load clamp: load_value 0x9A7C -> digits 0x5959; done cleared if previously set.

Source files
------------

// File: rtl/bcd_timer_ud_n_if.sv
// Control and count bus of the BCD timer core.
// master: the mode logic that drives the timer; slave: the timer itself.
interface bcd_timer_ud_n_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  tick;
    logic                  run;
    logic                  dir;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  inc;
    logic                  dec;
    logic [4*DIGITS-1:0]   digits;
    logic                  ovf;
    logic                  udf;
    logic                  done;

    modport master (
        output tick, run, dir, load, load_value, inc, dec,
        input  digits, ovf, udf, done
    );

    modport slave (
        input  tick, run, dir, load, load_value, inc, dec,
        output digits, ovf, udf, done
    );
endinterface

// File: rtl/bcd_timer_ud_n.sv
// Multi-digit loadable up/down BCD counter with per-digit modulus (6 or 10).
// Steps come from the time base (run=1) or from manual inc/dec (run=0);
// limits either wrap or saturate, with ovf/udf pulses and a done level.
module bcd_timer_ud_n #(
    parameter int unsigned       DIGITS   = 4,
    parameter logic [DIGITS-1:0] SEX_MASK = 4'b1010,
    parameter bit                WRAP     = 1'b1
) (
    input logic             clk,
    input logic             reset_p,
    bcd_timer_ud_n_if.slave bus
);

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                done_q, done_d;

    logic [4*DIGITS-1:0] up_val, dn_val, ld_val;
    logic                carry, borrow;
    logic                man_step, tick_step, step, step_up;

    // Ripple +1 / -1 through the digit chain and clamp the load value per digit.
    always_comb begin
        up_val = '0;
        dn_val = '0;
        ld_val = '0;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            logic [3:0] cur, top, lv;
            cur = cnt_q[4*i +: 4];
            top = SEX_MASK[i] ? 4'd5 : 4'd9;
            lv  = bus.load_value[4*i +: 4];

            if (!carry) begin
                up_val[4*i +: 4] = cur;
            end else if (cur == top) begin
                up_val[4*i +: 4] = 4'd0;
            end else begin
                up_val[4*i +: 4] = cur + 4'd1;
                carry            = 1'b0;
            end

            if (!borrow) begin
                dn_val[4*i +: 4] = cur;
            end else if (cur == 4'd0) begin
                dn_val[4*i +: 4] = top;
            end else begin
                dn_val[4*i +: 4] = cur - 4'd1;
                borrow           = 1'b0;
            end

            ld_val[4*i +: 4] = (lv > top) ? top : lv;
        end
    end

    // Select the step source: load beats manual adjust, which beats the time base.
    always_comb begin
        man_step  = !bus.run && (bus.inc ^ bus.dec);
        tick_step = bus.run && bus.tick;
        step      = !bus.load && (man_step || tick_step);
        step_up   = man_step ? bus.inc : bus.dir;
    end

    // Next count and flags. A carry/borrow out of the top digit leaves the
    // ripple result at all-zero/all-max, which is exactly the wrap result.
    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        done_d = done_q;
        if (bus.load) begin
            cnt_d  = ld_val;
            done_d = 1'b0;
        end else if (step) begin
            if (step_up) begin
                ovf_d  = carry;
                cnt_d  = (carry && !WRAP) ? cnt_q : up_val;
                done_d = 1'b0;
            end else begin
                udf_d = borrow;
                cnt_d = (borrow && !WRAP) ? cnt_q : dn_val;
                if (dn_val == '0 && cnt_q != '0) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            done_q <= done_d;
        end
    end

    assign bus.digits = cnt_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_bcd_timer_ud_n.sv
// Bench for bcd_timer_ud_n: a wrapping and a saturating instance share the
// same stimulus and are compared against an integer mixed-radix model.
module tb_bcd_timer_ud_n;

    localparam int unsigned   ND  = 4;
    localparam logic [ND-1:0] SEX = 4'b1010;

    logic clk;
    logic reset_p;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = wrapping DUT, 1 = saturating DUT
    int val [2];
    bit dn  [2];
    bit eo  [2];
    bit eu  [2];

    bcd_timer_ud_n_if #(.DIGITS(ND)) bw ();
    bcd_timer_ud_n_if #(.DIGITS(ND)) bs ();

    bcd_timer_ud_n #(.DIGITS(ND), .SEX_MASK(SEX), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset_p(reset_p), .bus(bw)
    );

    bcd_timer_ud_n #(.DIGITS(ND), .SEX_MASK(SEX), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset_p(reset_p), .bus(bs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int mod_of(int unsigned i);
        return SEX[i] ? 6 : 10;
    endfunction

    function automatic int max_val();
        int p = 1;
        for (int unsigned i = 0; i < ND; i++) p = p * mod_of(i);
        return p - 1;
    endfunction

    function automatic logic [4*ND-1:0] to_bcd(int n);
        logic [4*ND-1:0] r = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(n % mod_of(i));
            n = n / mod_of(i);
        end
        return r;
    endfunction

    function automatic int clamp_load(logic [4*ND-1:0] b);
        int v = 0;
        int w = 1;
        for (int unsigned i = 0; i < ND; i++) begin
            int d = int'(b[4*i +: 4]);
            if (d >= mod_of(i)) d = mod_of(i) - 1;
            v = v + d * w;
            w = w * mod_of(i);
        end
        return v;
    endfunction

    task automatic model_step(input int k, input bit up);
        if (up) begin
            dn[k] = 1'b0;
            if (val[k] == max_val()) begin
                eo[k] = 1'b1;
                if (k == 0) val[k] = 0;
            end else begin
                val[k] = val[k] + 1;
            end
        end else begin
            if (val[k] == 0) begin
                eu[k] = 1'b1;
                if (k == 0) val[k] = max_val();
            end else begin
                val[k] = val[k] - 1;
                if (val[k] == 0) dn[k] = 1'b1;
            end
        end
    endtask

    task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_one({tag, "/w.digits"}, 32'(bw.digits), 32'(to_bcd(val[0])));
        check_one({tag, "/w.ovf"},    32'(bw.ovf),    32'(eo[0]));
        check_one({tag, "/w.udf"},    32'(bw.udf),    32'(eu[0]));
        check_one({tag, "/w.done"},   32'(bw.done),   32'(dn[0]));
        check_one({tag, "/s.digits"}, 32'(bs.digits), 32'(to_bcd(val[1])));
        check_one({tag, "/s.ovf"},    32'(bs.ovf),    32'(eo[1]));
        check_one({tag, "/s.udf"},    32'(bs.udf),    32'(eu[1]));
        check_one({tag, "/s.done"},   32'(bs.done),   32'(dn[1]));
    endtask

    // apply one cycle of inputs to both DUTs, advance the model, check after the edge
    task automatic cycle(input bit t, input bit r, input bit dr, input bit ld,
                         input logic [4*ND-1:0] lv, input bit ic, input bit dc,
                         input string tag);
        bw.tick = t;  bw.run = r;  bw.dir = dr;  bw.load = ld;
        bw.load_value = lv;  bw.inc = ic;  bw.dec = dc;
        bs.tick = t;  bs.run = r;  bs.dir = dr;  bs.load = ld;
        bs.load_value = lv;  bs.inc = ic;  bs.dec = dc;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            eo[k] = 1'b0;
            eu[k] = 1'b0;
            if (ld) begin
                val[k] = clamp_load(lv);
                dn[k]  = 1'b0;
            end else if (!r && (ic ^ dc)) begin
                model_step(k, ic);
            end else if (r && t) begin
                model_step(k, dr);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            val[k] = 0; dn[k] = 1'b0; eo[k] = 1'b0; eu[k] = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        reset_p = 1'b1;
        cycle_inputs_zero();
        #23;
        check_all("reset");
        check_one("reset_digits", 32'(bw.digits), 32'h0);
        reset_p = 1'b0;

        // reset while counting
        cycle(0, 0, 1, 1, 16'h1234, 0, 0, "ld1234");
        repeat (5) cycle(1, 1, 1, 0, 16'h0, 0, 0, "tick_up");
        check_one("count_1239", 32'(bw.digits), 32'h1239);
        reset_p = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        check_one("rst_mid_digits", 32'(bw.digits), 32'h0);
        #1;
        reset_p = 1'b0;

        // up wrap and mod-6 carry
        cycle(0, 0, 1, 1, 16'h5958, 0, 0, "ld5958");
        cycle(1, 1, 1, 0, 16'h0, 0, 0, "up5959");
        check_one("up5959", 32'(bw.digits), 32'h5959);
        cycle(1, 1, 1, 0, 16'h0, 0, 0, "upwrap");
        check_one("upwrap_digits", 32'(bw.digits), 32'h0000);
        check_one("upwrap_ovf", 32'(bw.ovf), 32'h1);
        check_one("upsat_digits", 32'(bs.digits), 32'h5959);
        cycle(0, 1, 1, 0, 16'h0, 0, 0, "ovf_one_cycle");
        check_one("ovf_low", 32'(bw.ovf), 32'h0);
        cycle(0, 0, 1, 1, 16'h0959, 0, 0, "ld0959");
        cycle(1, 1, 1, 0, 16'h0, 0, 0, "carry6");
        check_one("carry6", 32'(bw.digits), 32'h1000);

        // countdown to done, then underflow
        cycle(0, 0, 0, 1, 16'h0002, 0, 0, "ld0002");
        cycle(1, 1, 0, 0, 16'h0, 0, 0, "dn0001");
        cycle(1, 1, 0, 0, 16'h0, 0, 0, "dn0000");
        check_one("done_set", 32'(bw.done), 32'h1);
        cycle(1, 1, 0, 0, 16'h0, 0, 0, "dnwrap");
        check_one("dnwrap_digits", 32'(bw.digits), 32'h5959);
        check_one("dnwrap_udf", 32'(bw.udf), 32'h1);
        check_one("dnwrap_done", 32'(bw.done), 32'h1);
        check_one("dnsat_digits", 32'(bs.digits), 32'h0000);

        // load clamp clears done
        cycle(0, 0, 0, 1, 16'h9A7C, 0, 0, "clamp");
        check_one("clamp_digits", 32'(bw.digits), 32'h5959);
        check_one("clamp_done", 32'(bw.done), 32'h0);

        // saturation on the non-wrapping instance, back-to-back pulses
        cycle(0, 0, 0, 1, 16'h0000, 0, 0, "ld0000");
        check_one("ld0_no_done", 32'(bs.done), 32'h0);
        cycle(1, 1, 0, 0, 16'h0, 0, 0, "sat_dn");
        check_one("sat_dn_udf", 32'(bs.udf), 32'h1);
        cycle(0, 0, 1, 1, 16'h5959, 0, 0, "ld5959");
        cycle(1, 1, 1, 0, 16'h0, 0, 0, "sat_up1");
        cycle(1, 1, 1, 0, 16'h0, 0, 0, "sat_up2");
        check_one("sat_up2_ovf", 32'(bs.ovf), 32'h1);
        check_one("sat_up2_digits", 32'(bs.digits), 32'h5959);

        // manual adjust and priority
        cycle(0, 0, 0, 1, 16'h0100, 0, 0, "ld0100");
        cycle(0, 0, 0, 0, 16'h0, 1, 0, "inc");
        check_one("inc", 32'(bw.digits), 32'h0101);
        cycle(0, 0, 0, 0, 16'h0, 0, 1, "dec");
        cycle(0, 0, 0, 0, 16'h0, 0, 1, "dec_borrow");
        check_one("dec_borrow", 32'(bw.digits), 32'h0059);
        cycle(0, 0, 0, 0, 16'h0, 1, 1, "inc_dec_hold");
        cycle(1, 0, 1, 0, 16'h0, 0, 0, "tick_paused");
        check_one("paused_hold", 32'(bw.digits), 32'h0059);
        cycle(0, 0, 0, 1, 16'h0042, 1, 0, "load_wins");
        check_one("load_wins", 32'(bw.digits), 32'h0042);
        cycle(0, 1, 1, 0, 16'h0, 1, 0, "inc_running");
        check_one("inc_running", 32'(bw.digits), 32'h0042);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit ld;
            ld = ($urandom_range(15) == 0);
            cycle(1'($urandom), 1'($urandom), 1'($urandom), ld,
                  16'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic cycle_inputs_zero();
        bw.tick = 0; bw.run = 0; bw.dir = 0; bw.load = 0; bw.load_value = '0; bw.inc = 0; bw.dec = 0;
        bs.tick = 0; bs.run = 0; bs.dir = 0; bs.load = 0; bs.load_value = '0; bs.inc = 0; bs.dec = 0;
    endtask

endmodule
